// File: rtl/jk_cmd_sequencer.sv
// jk_cmd_sequencer
// Feeds j/k of a downstream negedge JK flip-flop from a small command FIFO.
// Each command {op, rep} drives j/k = op for rep+1 consecutive cycles.
// Back-to-back commands are played without a bubble.
// A shadow copy of the JK state (q_model) is kept and checked against the
// flip-flop's fed-back q; any disagreement latches a sticky err flag.
// j/k are registered on posedge, so they are stable when the JK stage samples
// them on the following negedge.
module jk_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [CNT_W-1:0]         cmd_rep,
    output logic                     j,
    output logic                     k,
    input  logic                     q_fb,
    output logic                     q_model,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     err,
    input  logic                     err_clr
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 2 + CNT_W;
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     level_q;

    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head_entry;
    logic [1:0]         head_op;
    logic [CNT_W-1:0]   head_rep;

    // Ready depends only on occupancy so the source never sees a
    // combinational path from the pop side.
    assign cmd_ready  = (level_q != FULL_LEVEL);
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (level_q == '0);

    // Head is read straight out of the array so a command pushed at edge E
    // can be issued at edge E+1.
    assign head_entry = fifo_mem[rd_ptr_q];
    assign head_op    = head_entry[ENTRY_W-1 -: 2];
    assign head_rep   = head_entry[CNT_W-1:0];

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_op, cmd_rep};
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Issue FSM
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;
    logic             j_q;
    logic             j_d;
    logic             k_q;
    logic             k_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // State register for the issue sequencer and the j/k drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            j_q     <= j_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load from the FIFO head, count down remaining repeats,
    // and chain into the next command without an idle cycle.
    always_comb begin
        state_d = state_q;
        j_d     = j_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                j_d = 1'b0;
                k_d = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    {j_d, k_d} = head_op;
                    cnt_d      = head_rep;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!fifo_empty) begin
                    pop        = 1'b1;
                    {j_d, k_d} = head_op;
                    cnt_d      = head_rep;
                end else begin
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow JK model and consistency check
    // ------------------------------------------------------------------
    logic q_model_q;
    logic q_model_d;
    logic err_q;
    logic err_d;
    logic chk_en_q;
    logic mismatch;

    // JK truth table applied to the j/k that were on the wires during the
    // cycle that just ended.
    always_comb begin
        q_model_d = q_model_q;
        case ({j_q, k_q})
            2'b00:   q_model_d = q_model_q;
            2'b01:   q_model_d = 1'b0;
            2'b10:   q_model_d = 1'b1;
            default: q_model_d = ~q_model_q;
        endcase
    end

    // The JK stage has already acted on those j/k at the mid-cycle negedge,
    // so its q at this posedge is compared with the freshly predicted state.
    // The first edge after reset is skipped while the JK stage leaves reset.
    // A mismatch takes priority over err_clr.
    always_comb begin
        mismatch = chk_en_q && (q_fb != q_model_d);
        err_d    = err_q;
        if (mismatch) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Shadow state, sticky error and check-enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_model_q <= 1'b0;
            err_q     <= 1'b0;
            chk_en_q  <= 1'b0;
        end else begin
            q_model_q <= q_model_d;
            err_q     <= err_d;
            chk_en_q  <= 1'b1;
        end
    end

    assign j       = j_q;
    assign k       = k_q;
    assign q_model = q_model_q;
    assign err     = err_q;
    assign level   = level_q;
    assign busy    = (state_q == ST_ISSUE) || (level_q != '0);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Testbench for jk_cmd_sequencer: scoreboard of expected per-cycle j/k codes
// plus a behavioural JK flip-flop on the feedback path.
module tb_jk_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic                   clk;
    logic                   rst;
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [CNT_W-1:0]       cmd_rep;
    logic                   j;
    logic                   k;
    logic                   q_fb;
    logic                   q_model;
    logic                   busy;
    logic [$clog2(DEPTH):0] level;
    logic                   err;
    logic                   err_clr;

    logic jk_q;
    logic force_wrong;

    int tests = 0;
    int fails = 0;
    int unsigned edge_no = 0;

    // One entry per cycle that a command occupies on j/k.
    typedef struct {
        logic [1:0]  op;
        int unsigned tag;    // edge index at which the command was accepted
        bit          first;  // first cycle of its command
    } exp_t;

    exp_t exp_q[$];

    jk_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rep   (cmd_rep),
        .j         (j),
        .k         (k),
        .q_fb      (q_fb),
        .q_model   (q_model),
        .busy      (busy),
        .level     (level),
        .err       (err),
        .err_clr   (err_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream negedge JK stage, reset by rst_n = ~rst.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            jk_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   jk_q <= jk_q;
                2'b01:   jk_q <= 1'b0;
                2'b10:   jk_q <= 1'b1;
                default: jk_q <= ~jk_q;
            endcase
        end
    end

    assign q_fb = jk_q ^ force_wrong;

    function automatic logic jk_next(input logic q, input logic [1:0] code);
        case (code)
            2'b00:   return q;
            2'b01:   return 1'b0;
            2'b10:   return 1'b1;
            default: return ~q;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_no, act, exp_v);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at edge %0d", name, edge_no);
    endtask

    // Monitor: every posedge, advance the reference and compare all outputs.
    initial begin : monitor
        logic        s_rst;
        logic        s_qfb;
        logic        s_clr;
        logic        q_exp;
        logic [1:0]  jk_exp;
        logic        err_exp;
        logic        issuing;
        bit          first_after_rst;
        int unsigned cur;
        int unsigned lvl_exp;
        q_exp = 1'b0;
        jk_exp = 2'b00;
        err_exp = 1'b0;
        issuing = 1'b0;
        first_after_rst = 1'b1;
        forever begin
            @(posedge clk);
            s_rst = rst;
            s_qfb = q_fb;
            s_clr = err_clr;
            #1;
            cur = edge_no;
            if (s_rst) begin
                exp_q.delete();
                q_exp = 1'b0;
                jk_exp = 2'b00;
                err_exp = 1'b0;
                issuing = 1'b0;
                first_after_rst = 1'b1;
            end else begin
                q_exp = jk_next(q_exp, jk_exp);
                if (!first_after_rst && (s_qfb !== q_exp)) begin
                    err_exp = 1'b1;
                end else if (s_clr) begin
                    err_exp = 1'b0;
                end
                first_after_rst = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].tag < cur) begin
                    jk_exp = exp_q[0].op;
                    void'(exp_q.pop_front());
                    issuing = 1'b1;
                end else begin
                    jk_exp = 2'b00;
                    issuing = 1'b0;
                end
            end
            lvl_exp = 0;
            foreach (exp_q[n]) begin
                if (exp_q[n].first) lvl_exp++;
            end
            chk("jk",        {30'd0, j, k},          {30'd0, jk_exp});
            chk("q_model",   {31'd0, q_model},       {31'd0, q_exp});
            chk("err",       {31'd0, err},           {31'd0, err_exp});
            chk("level",     {29'd0, level},         lvl_exp);
            chk("cmd_ready", {31'd0, cmd_ready},     (lvl_exp != DEPTH) ? 32'd1 : 32'd0);
            chk("busy",      {31'd0, busy},          (issuing || lvl_exp != 0) ? 32'd1 : 32'd0);
            edge_no++;
        end
    end

    // Present one command and hold it until accepted; record its expected
    // per-cycle j/k codes at the accepting edge.
    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] rep);
        int tries;
        bit done;
        exp_t e;
        tries = 0;
        done = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rep   = rep;
        while (!done) begin
            #1;
            if (cmd_ready) begin
                @(posedge clk);
                for (int i = 0; i <= int'(rep); i++) begin
                    e.op    = op;
                    e.tag   = edge_no;
                    e.first = (i == 0);
                    exp_q.push_back(e);
                end
                done = 1'b1;
            end else begin
                tries++;
                if (tries > 400) begin
                    timeout_fail("send_accept");
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int waited;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_rep     = '0;
        err_clr     = 1'b0;
        force_wrong = 1'b0;

        // Reset for two cycles
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle(2);

        // set rep=0 then clr rep=2, back-to-back
        send(2'b10, 4'd0);
        send(2'b01, 4'd2);
        idle(6);

        // toggle rep=4: q goes 1,0,1,0,1
        send(2'b11, 4'd4);
        idle(8);

        // Long command stalls the FSM while the FIFO fills; fifth push waits
        send(2'b11, 4'd15);
        for (int i = 0; i < DEPTH + 1; i++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
        end
        idle(40);

        // Error flag: forced mismatch, clean clear, clear during mismatch
        @(negedge clk); force_wrong = 1'b1;
        @(negedge clk); force_wrong = 1'b0;
        idle(3);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        idle(2);
        @(negedge clk); err_clr = 1'b1; force_wrong = 1'b1;
        @(negedge clk); err_clr = 1'b0; force_wrong = 1'b0;
        idle(2);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        idle(2);

        // Reset in the middle of a toggle rep=7 with commands queued behind it
        send(2'b11, 4'd7);
        send(2'b10, 4'd1);
        send(2'b01, 4'd3);
        @(negedge clk); cmd_valid = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(20);

        // Randomised traffic with gaps, exercising pointer wraparound
        for (int i = 0; i < 60; i++) begin
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 5)));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 4)));
        end
        idle(1);

        // Drain the scoreboard
        waited = 0;
        while (exp_q.size() != 0 && waited < 800) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
